disp_colour_adapt: RTL and testbench

//  Parametrised display output stage between the display controller and the TMDS encoder.

---
 rtl/disp_pkg.sv | 25 ++
 rtl/colour_chan_conv.sv | 49 ++++
 rtl/disp_colour_adapt.sv | 114 +++++++++++
 tb/tb_disp_colour_adapt.sv | 139 +++++++++++++
 4 files changed

// File: rtl/disp_pkg.sv
// Shared definitions for the display colour adapter: Bayer table, counter width
// and the replicate/truncate width helper.
package disp_pkg;

    localparam int CORDW = 16;
    // Widest channel the width helper handles; channels must be narrower than this.
    localparam int MAXW  = 32;
    localparam int IW    = $clog2(MAXW);

    // 2x2 ordered-dither thresholds, indexed by {y[0]^fpar, x[0]}: {0,2,3,1}.
    localparam logic [3:0][1:0] BAYER = {2'd1, 2'd3, 2'd2, 2'd0};

    // MSB-first repeat of the low win bits of d, cut to wout bits.
    // Covers widening (bit replication), pass-through and plain truncation.
    function automatic logic [MAXW-1:0] rep_trunc(input logic [MAXW-1:0] d,
                                                  input int win, input int wout);
        logic [MAXW-1:0] r;
        r = '0;
        for (int i = 0; i < MAXW; i++) begin
            if (i < wout) r[IW'(wout - 1 - i)] = d[IW'(win - 1 - (i % win))];
        end
        return r;
    endfunction

endpackage

// File: rtl/colour_chan_conv.sv
// Converts one colour channel from BPC_IN to BPC_OUT bits; purely combinational.
module colour_chan_conv
    import disp_pkg::*;
#(
    parameter int BPC_IN  = 5,
    parameter int BPC_OUT = 8,
    parameter int DITHER  = 1
) (
    input  logic [BPC_IN-1:0]  in_d,
    input  logic               dith_en,
    input  logic [1:0]         dith_idx,
    output logic [BPC_OUT-1:0] out_d
);

    logic [MAXW-1:0]    rep_full;
    logic [BPC_OUT-1:0] base;
    logic               unused_rep;

    assign rep_full   = rep_trunc(MAXW'(in_d), BPC_IN, BPC_OUT);
    assign base       = rep_full[BPC_OUT-1:0];
    assign unused_rep = ^rep_full[MAXW-1:BPC_OUT];

    if (DITHER != 0 && BPC_OUT < BPC_IN) begin : g_dith
        localparam int D  = BPC_IN - BPC_OUT;
        localparam int SW = BPC_IN + 1;
        logic [1:0]    b;
        logic [SW-1:0] t;
        logic [SW-1:0] sum;
        logic          unused_lsb;

        assign b = BAYER[dith_idx];
        // Threshold scaled so the 2-bit Bayer value sits just below the kept bits.
        if (D >= 2) begin : g_shl
            assign t = SW'(b) << (D - 2);
        end else begin : g_shr
            assign t = SW'(b >> 1);
        end
        assign sum        = {1'b0, in_d} + t;
        assign unused_lsb = ^sum[D-1:0];
        // Saturate on carry so bright pixels never wrap to black.
        assign out_d = !dith_en   ? base :
                       sum[BPC_IN] ? '1  : sum[BPC_IN-1:D];
    end else begin : g_plain
        logic unused_dith;
        assign unused_dith = ^{dith_en, dith_idx};
        assign out_d       = base;
    end

endmodule

// File: rtl/disp_colour_adapt.sv
// Display output stage: per-channel depth conversion with optional temporal
// dither, RGB/BGR swap, blanking and a fixed-latency pipe for de/sync/colour.
module disp_colour_adapt
    import disp_pkg::*;
#(
    parameter int BPC_IN   = 5,
    parameter int BPC_OUT  = 8,
    parameter int CHANNELS = 3,
    parameter int PIPE     = 2,
    parameter int DITHER   = 1
) (
    input  logic                         clk_pix,
    input  logic                         rst_pix_n,
    input  logic                         en_dither,
    input  logic                         swap_rb,
    input  logic                         in_de,
    input  logic                         in_hsync,
    input  logic                         in_vsync,
    input  logic                         in_frame,
    input  logic [CHANNELS*BPC_IN-1:0]   in_colr,
    output logic                         out_de,
    output logic                         out_hsync,
    output logic                         out_vsync,
    output logic [CHANNELS*BPC_OUT-1:0]  out_colr
);

    localparam int CW = CHANNELS * BPC_OUT;
    localparam int PW = PIPE * CW;

    logic [CORDW-1:0] x_q, x_d, y_q, y_d;
    logic             fpar_q, fpar_d, de_prev_q, de_prev_d;
    logic [1:0]       dith_idx;

    logic [CHANNELS-1:0][BPC_IN-1:0]  in_ch, src_ch;
    logic [CHANNELS-1:0][BPC_OUT-1:0] conv_ch;
    logic [CW-1:0]                    blank_colr;

    logic [PIPE-1:0] de_pipe_q, de_pipe_d, hs_pipe_q, hs_pipe_d, vs_pipe_q, vs_pipe_d;
    logic [PW-1:0]   colr_pipe_q, colr_pipe_d;

    // Screen position and frame parity for the dither pattern; in_frame beats a de fall.
    always_comb begin
        x_d       = in_de ? x_q + CORDW'(1) : '0;
        de_prev_d = in_de;
        fpar_d    = fpar_q ^ in_frame;
        y_d       = y_q;
        if (in_frame)               y_d = '0;
        else if (de_prev_q && !in_de) y_d = y_q + CORDW'(1);
    end

    assign dith_idx = {y_q[0] ^ fpar_q, x_q[0]};
    assign in_ch    = in_colr;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        if (c == 0) begin : g_first
            assign src_ch[c] = swap_rb ? in_ch[CHANNELS-1] : in_ch[c];
        end else if (c == CHANNELS - 1) begin : g_last
            assign src_ch[c] = swap_rb ? in_ch[0] : in_ch[c];
        end else begin : g_mid
            assign src_ch[c] = in_ch[c];
        end

        colour_chan_conv #(
            .BPC_IN  (BPC_IN),
            .BPC_OUT (BPC_OUT),
            .DITHER  (DITHER)
        ) u_conv (
            .in_d     (src_ch[c]),
            .dith_en  (en_dither),
            .dith_idx (dith_idx),
            .out_d    (conv_ch[c])
        );
    end

    // Blank before the pipe so out_colr is zero whenever out_de is.
    assign blank_colr = in_de ? CW'(conv_ch) : '0;

    // Shift every pipe one stage; stage 0 takes the freshly converted pixel.
    always_comb begin
        de_pipe_d   = (de_pipe_q << 1) | PIPE'(in_de);
        hs_pipe_d   = (hs_pipe_q << 1) | PIPE'(in_hsync);
        vs_pipe_d   = (vs_pipe_q << 1) | PIPE'(in_vsync);
        colr_pipe_d = (colr_pipe_q << CW) | PW'(blank_colr);
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n) begin
            x_q         <= '0;
            y_q         <= '0;
            fpar_q      <= 1'b0;
            de_prev_q   <= 1'b0;
            de_pipe_q   <= '0;
            hs_pipe_q   <= '0;
            vs_pipe_q   <= '0;
            colr_pipe_q <= '0;
        end else begin
            x_q         <= x_d;
            y_q         <= y_d;
            fpar_q      <= fpar_d;
            de_prev_q   <= de_prev_d;
            de_pipe_q   <= de_pipe_d;
            hs_pipe_q   <= hs_pipe_d;
            vs_pipe_q   <= vs_pipe_d;
            colr_pipe_q <= colr_pipe_d;
        end
    end

    assign out_de    = de_pipe_q[PIPE-1];
    assign out_hsync = hs_pipe_q[PIPE-1];
    assign out_vsync = vs_pipe_q[PIPE-1];
    assign out_colr  = colr_pipe_q[PW-1 -: CW];

endmodule

// File: tb/tb_disp_colour_adapt.sv
// Directed bench: a widening (5->8) and a narrowing (8->5) instance share controls.
module tb_disp_colour_adapt;

    logic        clk_pix = 1'b0;
    logic        rst_pix_n = 1'b0;
    logic        en_dither = 1'b0, swap_rb = 1'b0;
    logic        in_de = 1'b0, in_hsync = 1'b0, in_vsync = 1'b0, in_frame = 1'b0;
    logic [14:0] colr_w = '0;
    logic [23:0] colr_n = '0;

    logic        de_w, hs_w, vs_w, de_n, hs_n, vs_n;
    logic [23:0] ocolr_w;
    logic [14:0] ocolr_n;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk_pix = ~clk_pix;

    disp_colour_adapt #(.BPC_IN(5), .BPC_OUT(8), .CHANNELS(3), .PIPE(2), .DITHER(1)) u_wide (
        .clk_pix (clk_pix), .rst_pix_n (rst_pix_n), .en_dither (en_dither), .swap_rb (swap_rb),
        .in_de (in_de), .in_hsync (in_hsync), .in_vsync (in_vsync), .in_frame (in_frame),
        .in_colr (colr_w), .out_de (de_w), .out_hsync (hs_w), .out_vsync (vs_w),
        .out_colr (ocolr_w)
    );

    disp_colour_adapt #(.BPC_IN(8), .BPC_OUT(5), .CHANNELS(3), .PIPE(2), .DITHER(1)) u_narrow (
        .clk_pix (clk_pix), .rst_pix_n (rst_pix_n), .en_dither (en_dither), .swap_rb (swap_rb),
        .in_de (in_de), .in_hsync (in_hsync), .in_vsync (in_vsync), .in_frame (in_frame),
        .in_colr (colr_n), .out_de (de_n), .out_hsync (hs_n), .out_vsync (vs_n),
        .out_colr (ocolr_n)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_pix);
        #1;
    endtask

    initial begin
        // Reset state
        #1;
        chk("rst_de_n", de_n, 0);
        chk("rst_colr_n", ocolr_n, 0);
        chk("rst_colr_w", ocolr_w, 0);
        chk("rst_hs_w", hs_w, 0);
        chk("rst_vs_n", vs_n, 0);
        step(); step();
        rst_pix_n = 1'b1;

        // Line 0, fpar=0 y=0: widening, dithered narrowing at x=0 and x=1
        in_de = 1; en_dither = 1;
        colr_w = {5'h00, 5'h10, 5'h1F};
        colr_n = {8'h04, 8'h04, 8'h04};
        step();
        chk("lat_de_n", de_n, 0);
        step();
        chk("wide_p0", ocolr_w, 24'h0084FF);
        chk("dith_x0", ocolr_n, 15'h0000);
        chk("de_w_p0", de_w, 1);
        in_de = 0; in_hsync = 1; colr_w = 15'h7FFF; colr_n = 24'hFFFFFF;
        step();
        chk("dith_x1", ocolr_n, 15'h0421);
        chk("wide_p1", ocolr_w, 24'h0084FF);
        in_hsync = 0;
        step();
        chk("blank_de_n", de_n, 0);
        chk("blank_colr_n", ocolr_n, 0);
        chk("blank_colr_w", ocolr_w, 0);
        chk("blank_hs_n", hs_n, 1);

        // Frame start: y=0, fpar=1; saturation; mid-line dither off + swap
        in_frame = 1;
        step();
        in_frame = 0;
        in_de = 1; en_dither = 1; swap_rb = 0;
        colr_n = {8'hFE, 8'h87, 8'h04};
        colr_w = {5'h00, 5'h10, 5'h1F};
        step();
        en_dither = 0; swap_rb = 1;
        step();
        chk("fpar_dith_sat", ocolr_n, 15'h7E21);
        chk("wide_noswap", ocolr_w, 24'h0084FF);
        in_de = 0; swap_rb = 0;
        step();
        chk("trunc_swap_n", ocolr_n, 15'h021F);
        chk("swap_w", ocolr_w, 24'hFF8400);

        // Sync passes through while blanked
        in_hsync = 1; in_vsync = 1;
        step();
        chk("blank2_colr_n", ocolr_n, 0);
        in_hsync = 0; in_vsync = 0;
        step();
        chk("sync_hs_n", hs_n, 1);
        chk("sync_vs_n", vs_n, 1);
        chk("sync_vs_w", vs_w, 1);
        chk("sync_colr_w", ocolr_w, 0);
        chk("sync_de_w", de_w, 0);
        step();
        chk("sync_vs_off", vs_n, 0);

        // Mid-line reset with x odd, y=1, fpar=1
        in_de = 1; in_hsync = 1; en_dither = 1;
        colr_n = 24'h040404; colr_w = 15'h7FFF;
        step(); step();
        chk("pre_rst_de_w", de_w, 1);
        chk("pre_rst_colr_w", ocolr_w, 24'hFFFFFF);
        step();
        #3 rst_pix_n = 0;
        #1;
        chk("arst_de_w", de_w, 0);
        chk("arst_colr_w", ocolr_w, 0);
        chk("arst_hs_w", hs_w, 0);
        chk("arst_de_n", de_n, 0);
        step();
        rst_pix_n = 1;
        step();
        chk("rel_lat_de_n", de_n, 0);
        step();
        chk("rel_de_n", de_n, 1);
        chk("rel_dith_x0", ocolr_n, 15'h0000);
        step();
        chk("rel_dith_x1", ocolr_n, 15'h0421);
        in_de = 0; in_hsync = 0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
